// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared definitions for the RAM port arbiter slice:
//   DEF_ADDR_W / DEF_DATA_W / DEF_PARK_ADDR : default geometry of the 64x8 RAM
//   arb_state_t                             : controller FSM states
//   req_id_t                                : requester identifier (two requesters)
//   gnt_to_id()                             : one-hot grant to requester id
package ram_arb_pkg;

  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_PARK_ADDR = 63;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CLR   = 2'd3
  } arb_state_t;

  typedef logic req_id_t;

  // Grants are one-hot or zero, so bit 1 alone identifies the winner.
  function automatic req_id_t gnt_to_id(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   req[1:0]  : request per requester
//   advance   : arbitration enabled this cycle; no grant when low
//   gnt[1:0]  : combinational grant, one-hot or zero
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // ptr=0 favours requester 0 on a tie, ptr=1 favours requester 1.
  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (advance) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // After serving requester i, priority passes to the other one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (|gnt) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares a 64x8 dual-port RAM (one write port, one registered read port,
// synchronous RAM reset) between two requesters. The write and read ports are
// arbitrated independently, RAM clears are sequenced at power-up and on
// request, and read data is returned tagged to the requester that asked.
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   wr_req/wr_addr/wr_data     : per-requester write requests (slice i = req i)
//   wr_gnt                     : combinational write grant
//   rd_req/rd_addr             : per-requester read requests
//   rd_gnt                     : combinational read grant
//   rd_rsp_valid/rd_rsp_data   : registered read response, 3 cycles after grant
//   clr_req/clr_done           : clear request (level) / completion pulse
//   err_park                   : pulse when a write to PARK_ADDR was dropped
//   ram_*                      : RAM interface (ram_dout is the only input)
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] PARK_ADDR = ADDR_W'(DEF_PARK_ADDR)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          wr_req,
  input  logic [2*ADDR_W-1:0] wr_addr,
  input  logic [2*DATA_W-1:0] wr_data,
  output logic [1:0]          wr_gnt,
  input  logic [1:0]          rd_req,
  input  logic [2*ADDR_W-1:0] rd_addr,
  output logic [1:0]          rd_gnt,
  output logic [1:0]          rd_rsp_valid,
  output logic [DATA_W-1:0]   rd_rsp_data,
  input  logic                clr_req,
  output logic                clr_done,
  output logic                err_park,
  output logic                ram_rst,
  output logic                ram_we_en,
  output logic [ADDR_W-1:0]   ram_we_addr,
  output logic [DATA_W-1:0]   ram_din,
  output logic                ram_rd_en,
  output logic [ADDR_W-1:0]   ram_re_addr,
  input  logic [DATA_W-1:0]   ram_dout
);

  arb_state_t state, state_next;
  logic grant_en;

  req_id_t wr_id, rd_id;
  logic [ADDR_W-1:0] wr_sel_addr, rd_sel_addr;
  logic [DATA_W-1:0] wr_sel_data;
  logic wr_issue, wr_park;

  // Read pipeline: ram_rd_en doubles as the stage-1 valid bit.
  req_id_t s1_id, s2_id;
  logic    s2_valid;

  rr_arb2 u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_req),
    .advance (grant_en),
    .gnt     (wr_gnt)
  );

  rr_arb2 u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_req),
    .advance (grant_en),
    .gnt     (rd_gnt)
  );

  assign wr_id       = gnt_to_id(wr_gnt);
  assign rd_id       = gnt_to_id(rd_gnt);
  assign wr_sel_addr = wr_id ? wr_addr[2*ADDR_W-1:ADDR_W] : wr_addr[ADDR_W-1:0];
  assign wr_sel_data = wr_id ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
  assign rd_sel_addr = rd_id ? rd_addr[2*ADDR_W-1:ADDR_W] : rd_addr[ADDR_W-1:0];
  assign wr_issue    = |wr_gnt;
  // The RAM zeroes PARK_ADDR on every idle cycle, so a real write there is
  // meaningless; it is granted (to keep the requester moving) but dropped.
  assign wr_park     = wr_issue && (wr_sel_addr == PARK_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // ram_rst is decoded from the state so it is already high while rst is
  // asserted and for the single INIT cycle after release.
  always_comb begin
    state_next = state;
    ram_rst    = 1'b0;
    grant_en   = 1'b0;
    case (state)
      ST_INIT: begin
        ram_rst    = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (clr_req) begin
          state_next = ST_DRAIN;
        end else begin
          grant_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!ram_rd_en && !s2_valid) begin
          state_next = ST_CLR;
        end
      end
      ST_CLR: begin
        ram_rst    = 1'b1;
        state_next = ST_RUN;
      end
      default: state_next = ST_INIT;
    endcase
  end

  // Write issue register: when nothing is written the address parks so the
  // RAM's idle zero-write lands on the scratch location.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we_en   <= 1'b0;
      ram_we_addr <= PARK_ADDR;
      ram_din     <= '0;
      err_park    <= 1'b0;
    end else begin
      ram_we_en   <= wr_issue && !wr_park;
      ram_we_addr <= (wr_issue && !wr_park) ? wr_sel_addr : PARK_ADDR;
      ram_din     <= (wr_issue && !wr_park) ? wr_sel_data : '0;
      err_park    <= wr_park;
    end
  end

  // Read pipeline: issue (stage 1), RAM output valid (stage 2), response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_rd_en    <= 1'b0;
      ram_re_addr  <= '0;
      s1_id        <= 1'b0;
      s2_valid     <= 1'b0;
      s2_id        <= 1'b0;
      rd_rsp_valid <= 2'b00;
      rd_rsp_data  <= '0;
      clr_done     <= 1'b0;
    end else begin
      ram_rd_en <= |rd_gnt;
      if (|rd_gnt) begin
        ram_re_addr <= rd_sel_addr;
        s1_id       <= rd_id;
      end
      s2_valid     <= ram_rd_en;
      s2_id        <= s1_id;
      rd_rsp_valid <= s2_valid ? (s2_id ? 2'b10 : 2'b01) : 2'b00;
      if (s2_valid) begin
        rd_rsp_data <= ram_dout;
      end
      clr_done <= (state == ST_CLR);
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Directed self-checking bench for ram_port_arbiter with a behavioural 64x8
// RAM (registered read, read-before-write, idle cycles write zero to the
// write address, synchronous clear).
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  wr_req = 2'b00;
  logic [11:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_gnt;
  logic [1:0]  rd_req = 2'b00;
  logic [11:0] rd_addr = '0;
  logic [1:0]  rd_gnt;
  logic [1:0]  rd_rsp_valid;
  logic [7:0]  rd_rsp_data;
  logic        clr_req = 1'b0;
  logic        clr_done;
  logic        err_park;
  logic        ram_rst;
  logic        ram_we_en;
  logic [5:0]  ram_we_addr;
  logic [7:0]  ram_din;
  logic        ram_rd_en;
  logic [5:0]  ram_re_addr;
  logic [7:0]  ram_dout;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] mem [64];

  ram_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_gnt       (wr_gnt),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_gnt       (rd_gnt),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .clr_req      (clr_req),
    .clr_done     (clr_done),
    .err_park     (err_park),
    .ram_rst      (ram_rst),
    .ram_we_en    (ram_we_en),
    .ram_we_addr  (ram_we_addr),
    .ram_din      (ram_din),
    .ram_rd_en    (ram_rd_en),
    .ram_re_addr  (ram_re_addr),
    .ram_dout     (ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural RAM sitting behind the arbiter.
  always @(posedge clk) begin
    if (ram_rst) begin
      for (int k = 0; k < 64; k++) mem[k] <= 8'h00;
      ram_dout <= 8'h00;
    end else begin
      if (ram_rd_en) ram_dout <= mem[ram_re_addr];
      mem[ram_we_addr] <= ram_we_en ? ram_din : 8'h00;
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    tick;
    tests_run++;
    if (ram_rst !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_ram_rst: got %b expected 1", ram_rst);
    end
    tests_run++;
    if ({ram_we_en, ram_rd_en, clr_done, err_park} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes: got we/rd/clr/park %b expected 0000",
               {ram_we_en, ram_rd_en, clr_done, err_park});
    end
    tests_run++;
    if (ram_we_addr !== 6'd63 || ram_re_addr !== 6'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_addr: got we_addr %0d re_addr %0d expected 63 0",
               ram_we_addr, ram_re_addr);
    end
    tests_run++;
    if (rd_rsp_valid !== 2'b00 || rd_rsp_data !== 8'h00 || ram_din !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_rsp: got valid %b data %h din %h expected 00 00 00",
               rd_rsp_valid, rd_rsp_data, ram_din);
    end
    rst = 1'b0;
    wr_req = 2'b01;
    #1;
    tests_run++;
    if (ram_rst !== 1'b1 || wr_gnt !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL init_cycle: got ram_rst %b wr_gnt %b expected 1 00", ram_rst, wr_gnt);
    end
    wr_req = 2'b00;
    tick;
    tests_run++;
    if (ram_rst !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL run_ram_rst: got %b expected 0", ram_rst);
    end
  endtask

  task automatic test_basic_write;
    wr_req = 2'b01;
    wr_addr = {6'd0, 6'd5};
    wr_data = {8'h00, 8'hA5};
    #1;
    tests_run++;
    if (wr_gnt !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL basic_wr_gnt: got %b expected 01", wr_gnt);
    end
    tick;
    wr_req = 2'b00;
    tests_run++;
    if (ram_we_en !== 1'b1 || ram_we_addr !== 6'd5 || ram_din !== 8'hA5) begin
      tests_failed++;
      $display("[TB] FAIL basic_wr_issue: got en %b addr %0d din %h expected 1 5 a5",
               ram_we_en, ram_we_addr, ram_din);
    end
    tick;
    tests_run++;
    if (ram_we_en !== 1'b0 || ram_we_addr !== 6'd63) begin
      tests_failed++;
      $display("[TB] FAIL basic_wr_park: got en %b addr %0d expected 0 63", ram_we_en, ram_we_addr);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_seq [4];
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    // A lone grant to requester 1 hands the next tie to requester 0.
    wr_req = 2'b10;
    wr_addr = {6'd3, 6'd0};
    wr_data = {8'h03, 8'h00};
    #1;
    tests_run++;
    if (wr_gnt !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL rr_single: got %b expected 10", wr_gnt);
    end
    tick;
    wr_req = 2'b11;
    wr_addr = {6'd2, 6'd1};
    wr_data = {8'h22, 8'h11};
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (wr_gnt !== exp_seq[i]) begin
        tests_failed++;
        $display("[TB] FAIL rr_tie_%0d: got %b expected %b", i, wr_gnt, exp_seq[i]);
      end
      tick;
    end
    wr_req = 2'b00;
  endtask

  task automatic test_write_then_read;
    wr_req = 2'b01;
    wr_addr = {6'd0, 6'd10};
    wr_data = {8'h00, 8'h3C};
    tick;
    wr_req = 2'b00;
    rd_req = 2'b10;
    rd_addr = {6'd10, 6'd0};
    #1;
    tests_run++;
    if (rd_gnt !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL wr_rd_gnt: got %b expected 10", rd_gnt);
    end
    tick;
    rd_req = 2'b00;
    tests_run++;
    if (ram_rd_en !== 1'b1 || ram_re_addr !== 6'd10 || rd_rsp_valid !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL wr_rd_issue: got rd_en %b addr %0d valid %b expected 1 10 00",
               ram_rd_en, ram_re_addr, rd_rsp_valid);
    end
    tick;
    tests_run++;
    if (rd_rsp_valid !== 2'b00 || ram_rd_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wr_rd_t2: got valid %b rd_en %b expected 00 0", rd_rsp_valid, ram_rd_en);
    end
    tick;
    tests_run++;
    if (rd_rsp_valid !== 2'b10 || rd_rsp_data !== 8'h3C) begin
      tests_failed++;
      $display("[TB] FAIL wr_rd_rsp: got valid %b data %h expected 10 3c", rd_rsp_valid, rd_rsp_data);
    end
    tick;
    tests_run++;
    if (rd_rsp_valid !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL wr_rd_after: got valid %b expected 00", rd_rsp_valid);
    end
  endtask

  task automatic test_hazard;
    wr_req = 2'b01;
    wr_addr = {6'd0, 6'd20};
    wr_data = {8'h00, 8'h11};
    tick;
    wr_data = {8'h00, 8'h77};
    rd_req = 2'b01;
    rd_addr = {6'd0, 6'd20};
    #1;
    tests_run++;
    if (wr_gnt !== 2'b01 || rd_gnt !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL hazard_gnt: got wr %b rd %b expected 01 01", wr_gnt, rd_gnt);
    end
    tick;
    wr_req = 2'b00;
    #1;
    tests_run++;
    if (rd_gnt !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL hazard_gnt2: got %b expected 01", rd_gnt);
    end
    tick;
    rd_req = 2'b00;
    tick;
    tests_run++;
    if (rd_rsp_valid !== 2'b01 || rd_rsp_data !== 8'h11) begin
      tests_failed++;
      $display("[TB] FAIL hazard_old: got valid %b data %h expected 01 11", rd_rsp_valid, rd_rsp_data);
    end
    tick;
    tests_run++;
    if (rd_rsp_valid !== 2'b01 || rd_rsp_data !== 8'h77) begin
      tests_failed++;
      $display("[TB] FAIL hazard_new: got valid %b data %h expected 01 77", rd_rsp_valid, rd_rsp_data);
    end
  endtask

  task automatic test_park;
    wr_req = 2'b01;
    wr_addr = {6'd0, 6'd63};
    wr_data = {8'h00, 8'h55};
    rd_req = 2'b01;
    rd_addr = {6'd0, 6'd63};
    #1;
    tests_run++;
    if (wr_gnt !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL park_gnt: got %b expected 01", wr_gnt);
    end
    tick;
    wr_req = 2'b00;
    rd_req = 2'b00;
    tests_run++;
    if (ram_we_en !== 1'b0 || err_park !== 1'b1 || ram_we_addr !== 6'd63) begin
      tests_failed++;
      $display("[TB] FAIL park_drop: got en %b err %b addr %0d expected 0 1 63",
               ram_we_en, err_park, ram_we_addr);
    end
    tick;
    tests_run++;
    if (err_park !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL park_pulse: got %b expected 0", err_park);
    end
    tick;
    tests_run++;
    if (rd_rsp_valid !== 2'b01 || rd_rsp_data !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL park_read: got valid %b data %h expected 01 00", rd_rsp_valid, rd_rsp_data);
    end
  endtask

  task automatic test_clear;
    rd_req = 2'b01;
    rd_addr = {6'd20, 6'd10};
    #1;
    tests_run++;
    if (rd_gnt !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL clr_rd0_gnt: got %b expected 01", rd_gnt);
    end
    tick;
    rd_req = 2'b10;
    #1;
    tests_run++;
    if (rd_gnt !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL clr_rd1_gnt: got %b expected 10", rd_gnt);
    end
    tick;
    clr_req = 1'b1;
    rd_req = 2'b01;
    #1;
    tests_run++;
    if (rd_gnt !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL clr_seen_gnt: got %b expected 00", rd_gnt);
    end
    tick;
    clr_req = 1'b0;
    #1;
    tests_run++;
    if (rd_gnt !== 2'b00 || rd_rsp_valid !== 2'b01 || rd_rsp_data !== 8'h3C || ram_rst !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clr_drain1: got gnt %b valid %b data %h rst %b expected 00 01 3c 0",
               rd_gnt, rd_rsp_valid, rd_rsp_data, ram_rst);
    end
    tick;
    tests_run++;
    if (rd_gnt !== 2'b00 || rd_rsp_valid !== 2'b10 || rd_rsp_data !== 8'h77 || ram_rst !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clr_drain2: got gnt %b valid %b data %h rst %b expected 00 10 77 0",
               rd_gnt, rd_rsp_valid, rd_rsp_data, ram_rst);
    end
    tick;
    tests_run++;
    if (ram_rst !== 1'b1 || clr_done !== 1'b0 || rd_gnt !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL clr_pulse: got rst %b done %b gnt %b expected 1 0 00", ram_rst, clr_done, rd_gnt);
    end
    tick;
    tests_run++;
    if (ram_rst !== 1'b0 || clr_done !== 1'b1 || rd_gnt !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL clr_done: got rst %b done %b gnt %b expected 0 1 01", ram_rst, clr_done, rd_gnt);
    end
    tick;
    rd_req = 2'b00;
    tests_run++;
    if (clr_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clr_done_once: got %b expected 0", clr_done);
    end
    tick;
    tick;
    tests_run++;
    if (rd_rsp_valid !== 2'b01 || rd_rsp_data !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL clr_readback: got valid %b data %h expected 01 00", rd_rsp_valid, rd_rsp_data);
    end
  endtask

  task automatic test_reset_midflight;
    rd_req = 2'b01;
    rd_addr = {6'd0, 6'd5};
    #1;
    tests_run++;
    if (rd_gnt !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL mid_gnt: got %b expected 01", rd_gnt);
    end
    tick;
    rd_req = 2'b00;
    rst = 1'b1;
    #1;
    tests_run++;
    if (ram_rd_en !== 1'b0 || ram_rst !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_rst: got rd_en %b ram_rst %b expected 0 1", ram_rd_en, ram_rst);
    end
    tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      tests_run++;
      if (rd_rsp_valid !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL mid_no_rsp_%0d: got %b expected 00", i, rd_rsp_valid);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic_write;
    test_back_to_back;
    test_write_then_read;
    test_hazard;
    test_park;
    test_clear;
    test_reset_midflight;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
